// File: rtl/threshold_display.sv
// Converts the 8-bit threshold to three BCD digits with a sequential
// double-dabble engine and drives three registered active-low 7-segment displays.
module threshold_display #(
    parameter bit LEADING_ZERO_BLANK = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] threshold,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    state_t      state, next_state;
    logic [7:0]  last_value;
    logic [7:0]  sh;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [3:0]  cnt;
    logic [3:0]  dig2, dig1, dig0;
    logic        blank2, blank1;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    assign blank2  = LEADING_ZERO_BLANK && (dig2 == 4'd0);
    assign blank1  = LEADING_ZERO_BLANK && (dig2 == 4'd0) && (dig1 == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (threshold != last_value) next_state = SHIFT;
            SHIFT:   if (cnt == 4'd7) next_state = LATCH;
            LATCH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_value <= 8'd0;
            sh         <= 8'd0;
            bcd        <= 12'd0;
            cnt        <= 4'd0;
            dig2       <= 4'd0;
            dig1       <= 4'd0;
            dig0       <= 4'd0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (threshold != last_value) begin
                        last_value <= threshold;
                        sh         <= threshold;
                        bcd        <= 12'd0;
                        cnt        <= 4'd0;
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    // correct every nibble first, then shift bcd and sh as one 20-bit word
                    {bcd, sh} <= {bcd_adj, sh} << 1;
                    cnt       <= cnt + 4'd1;
                end
                LATCH: begin
                    dig2 <= bcd[11:8];
                    dig1 <= bcd[7:4];
                    dig0 <= bcd[3:0];
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hex0 <= SEG_ZERO;
            hex1 <= LEADING_ZERO_BLANK ? SEG_BLANK : SEG_ZERO;
            hex2 <= LEADING_ZERO_BLANK ? SEG_BLANK : SEG_ZERO;
        end else begin
            hex0 <= seg7(dig0);
            hex1 <= blank1 ? SEG_BLANK : seg7(dig1);
            hex2 <= blank2 ? SEG_BLANK : seg7(dig2);
        end
    end

endmodule

// File: tb/tb_threshold_display.sv
// Self-checking bench for threshold_display: directed timing cases plus random
// values compared against a decimal-arithmetic display model, for both blanking modes.
module tb_threshold_display;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] threshold;
    logic [6:0] a_hex0, a_hex1, a_hex2, b_hex0, b_hex1, b_hex2;
    logic       a_busy, b_busy;
    int         errors = 0;
    int         checks = 0;

    threshold_display #(.LEADING_ZERO_BLANK(1'b1)) dut_blank (
        .clock(clock), .reset(reset), .threshold(threshold),
        .hex0(a_hex0), .hex1(a_hex1), .hex2(a_hex2), .busy(a_busy)
    );

    threshold_display #(.LEADING_ZERO_BLANK(1'b0)) dut_full (
        .clock(clock), .reset(reset), .threshold(threshold),
        .hex0(b_hex0), .hex1(b_hex1), .hex2(b_hex2), .busy(b_busy)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected segment pattern of digit position pos (0 = units) when v is shown.
    function automatic logic [6:0] exp_hex(input int v, input bit lzb, input int pos);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (pos == 2) return (lzb && h == 0) ? 7'b1111111 : seg(h);
        if (pos == 1) return (lzb && h == 0 && t == 0) ? 7'b1111111 : seg(t);
        return seg(u);
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_busy(input string tag, input logic exp);
        check({tag, "_a"}, {6'd0, a_busy}, {6'd0, exp});
        check({tag, "_b"}, {6'd0, b_busy}, {6'd0, exp});
    endtask

    task automatic check_display(input string tag, input int v);
        check({tag, "_blank_hex2"}, a_hex2, exp_hex(v, 1'b1, 2));
        check({tag, "_blank_hex1"}, a_hex1, exp_hex(v, 1'b1, 1));
        check({tag, "_blank_hex0"}, a_hex0, exp_hex(v, 1'b1, 0));
        check({tag, "_full_hex2"},  b_hex2, exp_hex(v, 1'b0, 2));
        check({tag, "_full_hex1"},  b_hex1, exp_hex(v, 1'b0, 1));
        check({tag, "_full_hex0"},  b_hex0, exp_hex(v, 1'b0, 0));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int v;
        int k;

        // reset state and quiet period
        reset = 1'b1;
        threshold = 8'd0;
        tick(2);
        check_display("reset", 0);
        check_busy("reset_busy", 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_busy("idle_busy", 1'b0);
        end
        check_display("idle20", 0);

        // value 100: busy for exactly 9 cycles, display after 10
        threshold = 8'd100;
        tick(1);
        for (int i = 0; i < 9; i++) begin
            check_busy("busy100_high", 1'b1);
            tick(1);
        end
        check_busy("busy100_low", 1'b0);
        check_display("before100", 0);
        tick(1);
        check_display("val100", 100);

        threshold = 8'd255;
        tick(11);
        check_display("val255", 255);

        threshold = 8'd5;
        tick(11);
        check_display("val5", 5);

        threshold = 8'd250;
        tick(11);
        check_display("val250", 250);
        threshold = 8'd4;
        tick(11);
        check_display("wrap4", 4);

        // change 100 -> 110 three cycles into SHIFT
        threshold = 8'd100;
        tick(1);
        tick(3);
        threshold = 8'd110;
        tick(6);
        check_busy("mid_gap", 1'b0);
        tick(1);
        check_display("mid_first", 100);
        check_busy("mid_restart", 1'b1);
        tick(10);
        check_display("mid_final", 110);

        // reset during SHIFT with threshold = 200
        threshold = 8'd200;
        tick(1);
        tick(4);
        check_busy("rst_pre", 1'b1);
        reset = 1'b1;
        #1;
        check_busy("rst_async", 1'b0);
        check_display("rst_async", 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check_busy("rst_restart", 1'b1);
        tick(10);
        check_display("rst_val200", 200);

        // random single values with full settle time
        for (int i = 0; i < 30; i++) begin
            v = $urandom_range(0, 255);
            threshold = v[7:0];
            tick(11);
            check_display("rand", v);
        end

        // random bursts: the last value written must end up on the display
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(1, 5);
            for (int j = 0; j < k; j++) begin
                v = $urandom_range(0, 255);
                threshold = v[7:0];
                tick($urandom_range(1, 6));
            end
            tick(25);
            check_display("burst", v);
            check_busy("burst_busy", 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
